// File: rtl/nios_data_arbiter_pkg.sv
// Shared types and constants for the PIO data arbiter.
// No logic of its own; no latency.
// No flow control here; consumers apply their own handshakes.
package nios_data_arbiter_pkg;

  // Sequencer states: arbitration, slave write, optional read-back
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2
  } state_t;

  // Register offset whose writes are read back and compared
  localparam logic [1:0] DATA_REG_ADDR = 2'd0;

  // Default geometry, matching the PIO output register slave
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 2;

  // Next round-robin start position after index idx, wrapping at n
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/nios_data_arbiter_rr.sv
// Round-robin request picker: highest priority at ptr, then ptr+1, wrapping.
// Purely combinational, zero latency.
// enable low forces an all-zero grant so nothing is accepted.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          enable,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW:0] pos;
  logic        found;

  // Scan from ptr upward modulo N; the first asserted request wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (enable && !found && req[pos[IW-1:0]]) begin
        found                = 1'b1;
        grant[pos[IW-1:0]]   = 1'b1;
        grant_idx            = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/nios_data_arbiter.sv
// Shares one PIO register slave among NUM_REQ requesters; one zero-wait write per grant.
// Grant G, write G+1, optional read-back G+2; done pulse G+2 (G+3 with read-back).
// req_ready only pulses while idle; requests seen while busy are ignored, never queued.
module nios_data_arbiter
  import nios_data_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int VERIFY  = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_writedata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       done_valid,
  output logic [$clog2(NUM_REQ)-1:0] done_id,
  output logic                       done_error,
  output logic                       busy,
  output logic [ADDR_W-1:0]          address,
  output logic                       chipselect,
  output logic                       write_n,
  output logic [DATA_W-1:0]          writedata,
  input  logic [DATA_W-1:0]          readdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [IDX_W-1:0]   id_q;
  logic               done_valid_q, done_valid_d;
  logic               done_error_q, done_error_d;
  logic [IDX_W-1:0]   done_id_q, done_id_d;
  logic               capture;
  logic               arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  // Arbitrate only when idle; held off while reset is asserted so no accept pulse leaks out
  assign arb_en = (state_q == ST_IDLE) && reset_n;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready  = grant;
  assign address    = addr_q;
  assign writedata  = data_q;
  assign done_valid = done_valid_q;
  assign done_id    = done_id_q;
  assign done_error = done_error_q;

  // Next state, slave strobes and completion status for the next cycle
  always_comb begin
    state_d      = state_q;
    done_valid_d = 1'b0;
    done_error_d = done_error_q;
    done_id_d    = done_id_q;
    capture      = 1'b0;
    chipselect   = 1'b0;
    write_n      = 1'b1;
    busy         = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          capture = 1'b1;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        busy       = 1'b1;
        if ((VERIFY != 0) && (addr_q == ADDR_W'(DATA_REG_ADDR))) begin
          state_d = ST_VERIFY;
        end else begin
          state_d      = ST_IDLE;
          done_valid_d = 1'b1;
          done_error_d = 1'b0;
          done_id_d    = id_q;
        end
      end
      ST_VERIFY: begin
        chipselect   = 1'b1;
        busy         = 1'b1;
        state_d      = ST_IDLE;
        done_valid_d = 1'b1;
        done_error_d = (readdata != data_q);
        done_id_d    = id_q;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and completion registers; reset aborts any in-flight transaction silently
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      done_valid_q <= 1'b0;
      done_error_q <= 1'b0;
      done_id_q    <= '0;
    end else begin
      state_q      <= state_d;
      done_valid_q <= done_valid_d;
      done_error_q <= done_error_d;
      done_id_q    <= done_id_d;
    end
  end

  // Latch the winner's payload and advance the round-robin pointer past it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else if (capture) begin
      addr_q <= req_address[grant_idx*ADDR_W +: ADDR_W];
      data_q <= req_writedata[grant_idx*DATA_W +: DATA_W];
      id_q   <= grant_idx;
      ptr_q  <= IDX_W'(wrap_inc(int'(grant_idx), NUM_REQ));
    end
  end

endmodule
